gpio_bus_arb: RTL and testbench
===============================

GPIO_BUS_ARB -- requirements
Module: gpio_bus_arb

Interface
REQ-001 Parameter ADDR_W, default 8: width of the peripheral register address.
REQ-002 Parameter DATA_W, default 8: width of the peripheral register data.
REQ-003 clk  in  1  the single clock; all logic SHALL be on its rising edge.
REQ-004 reset  in  1  reset, synchronous and active-high.
REQ-005 m0_req, m1_req  in  1 each  transaction request (level), held by the master until its ack.
REQ-006 m0_wr, m1_wr  in  1 each  operation select: 1 = write, 0 = read; valid while req is high.
REQ-007 m0_addr, m1_addr  in  ADDR_W each  register address; valid while req is high.
REQ-008 m0_wdata, m1_wdata  in  DATA_W each  write data; valid while req is high.
REQ-009 m0_ack, m1_ack  out  1 each  one-cycle pulse marking transaction completion.
REQ-010 m0_rdata, m1_rdata  out  DATA_W each  read result; valid in the ack cycle and held until that master's next read completes.
REQ-011 bus_addr  out  ADDR_W  shared peripheral address, registered.
REQ-012 bus_do  out  DATA_W  shared peripheral write data, registered.
REQ-013 bus_rd, bus_wr  out  1 each  shared peripheral strobes, registered.
REQ-014 bus_di  in  DATA_W  peripheral read data; the peripheral registers it one cycle after the address is presented.
REQ-015 busy  out  1  high in every non-IDLE state.

Function
REQ-016 States: IDLE, ACCESS, RDWAIT, DONE; the encoding SHALL be registered.
REQ-017 IDLE, no request: remain in IDLE; bus_rd = bus_wr = 0.
REQ-018 IDLE, any request:
- latch the winner's op, addr and wdata into internal registers;
- record the owner;
- go to ACCESS.
REQ-019 Arbitration SHALL be two-way round robin:
- a single requester wins;
- when both request, the master not granted last wins;
- the last-granted pointer updates on every grant.
REQ-020 ACCESS:
- bus_addr = latched addr; bus_do = latched wdata;
- exactly one of bus_wr / bus_rd = 1 for this single cycle;
- next state is DONE for a write, RDWAIT for a read.
REQ-021 RDWAIT:
- bus_addr held, strobes 0;
- at the end of the cycle, capture bus_di into the owner's rdata register;
- go to DONE.
REQ-022 DONE:
- owner's ack = 1 for exactly one cycle, the other master's ack = 0;
- return to IDLE.
REQ-023 Latency from the IDLE cycle in which req is sampled high: write ack 2 cycles later; read ack 3 cycles later.
REQ-024 Requests are not sampled outside IDLE; the losing master's request stays pending and SHALL be granted at the next IDLE.
REQ-025 A master holding req high through its ack cycle SHALL start a new transaction at the following IDLE (back-to-back: one IDLE cycle between transactions).
REQ-026 Changes to req, addr, wdata or wr after the IDLE sampling cycle SHALL NOT affect the transaction in flight.
REQ-027 bus_addr and bus_do SHALL retain their last values in IDLE and DONE.
REQ-028 The non-owner's rdata SHALL never change during another master's transaction.

Reset
REQ-029 While reset is high, at the next edge:
- state = IDLE;
- bus_addr, bus_do, bus_rd, bus_wr, m0_ack, m1_ack, m0_rdata, m1_rdata = 0;
- busy = 0;
- last-granted pointer = master 1, so master 0 wins the first tie.
REQ-030 Reset during ACCESS, RDWAIT or DONE SHALL abort the transaction: no ack and no further strobe after the reset edge.

Structure
REQ-031 A shared package SHALL hold the state enumeration, and the op encoding constants OP_RD = 0 and OP_WR = 1.
REQ-032 One sub-module, rr_arb2, SHALL hold the combinational two-request round-robin decision plus the registered last-granted pointer.
REQ-033 The rr_arb2 sub-module SHALL have ports clk, reset, req[1:0], advance, gnt[1:0] (one-hot).

Verification
REQ-034 Write: m0 write, addr 0x01, wdata 0xA5 -> bus_wr = 1 with bus_addr 0x01, bus_do 0xA5 one cycle after sampling; m0_ack one cycle later; m1_ack stays 0.
REQ-035 Read: m1 read, addr 0x42; model drives bus_di = 0x5C one cycle after the address -> bus_rd pulses once; m1_ack 3 cycles after sampling with m1_rdata = 0x5C; m0_rdata unchanged.
REQ-036 Tie and fairness:
- both masters hold req for writes from reset -> grants alternate m0, m1, m0, m1;
- each ack 3 cycles after the previous one;
- no strobe overlap.
REQ-037 Abort: reset asserted in RDWAIT of an m0 read -> no m0_ack, m0_rdata = 0, bus_rd = 0; after reset release, the first tie goes to m0.
REQ-038 Late changes: m0_addr changed from 0x03 to 0x44 in the cycle after sampling -> bus_addr = 0x03 for the whole transaction.

Source files
------------

// File: rtl/gpio_bus_arb_pkg.sv
// Shared types for the two-master peripheral bus arbiter: FSM state
// enumeration and the read/write op encoding.
package gpio_bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

endpackage

// File: rtl/gpio_bus_arb_rr_arb2.sv
// Two-request round-robin arbiter: combinational one-hot grant plus the
// registered last-granted pointer (1 = master 1 was granted last).
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  // NOTE: every signal driven here gets a default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    gnt    = req;
    last_d = last_q;
    if (req == 2'b11) begin
      gnt = last_q ? 2'b01 : 2'b10;
    end
    if (advance && (req != 2'b00)) begin
      last_d = gnt[1];
    end
  end

  // Pointer resets to master 1 so that master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/gpio_bus_arb.sv
// Two-master arbiter onto a single registered peripheral bus: round-robin
// grant in IDLE, one-cycle strobe, optional read wait, one-cycle ack.
module gpio_bus_arb
  import gpio_bus_arb_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_wr,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_wr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_do,
  output logic              bus_rd,
  output logic              bus_wr,
  input  logic [DATA_W-1:0] bus_di,
  output logic              busy
);

  state_e            state_q, state_d;
  logic              op_q, op_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_do_q, bus_do_d;
  logic              bus_rd_q, bus_rd_d;
  logic              bus_wr_q, bus_wr_d;
  logic [1:0]        ack_q, ack_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic [1:0]        gnt;
  logic              advance;
  logic              win_wr;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({m1_req, m0_req}),
    .advance (advance),
    .gnt     (gnt)
  );

  always_comb begin
    win_wr    = gnt[1] ? m1_wr    : m0_wr;
    win_addr  = gnt[1] ? m1_addr  : m0_addr;
    win_wdata = gnt[1] ? m1_wdata : m0_wdata;
  end

  // The bus address/data registers double as the latched transaction
  // fields: they load only on a grant and hold through IDLE and DONE.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    owner_d    = owner_q;
    bus_addr_d = bus_addr_q;
    bus_do_d   = bus_do_q;
    bus_rd_d   = 1'b0;
    bus_wr_d   = 1'b0;
    ack_d      = 2'b00;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    advance    = 1'b0;

    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          advance    = 1'b1;
          owner_d    = gnt[1];
          op_d       = win_wr;
          bus_addr_d = win_addr;
          bus_do_d   = win_wdata;
          bus_wr_d   = (win_wr == OP_WR);
          bus_rd_d   = (win_wr == OP_RD);
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        if (op_q == OP_WR) begin
          ack_d[owner_q] = 1'b1;
          state_d        = DONE;
        end else begin
          state_d = RDWAIT;
        end
      end
      RDWAIT: begin
        if (owner_q) begin
          rdata1_d = bus_di;
        end else begin
          rdata0_d = bus_di;
        end
        ack_d[owner_q] = 1'b1;
        state_d        = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_RD;
      owner_q    <= 1'b0;
      bus_addr_q <= '0;
      bus_do_q   <= '0;
      bus_rd_q   <= 1'b0;
      bus_wr_q   <= 1'b0;
      ack_q      <= 2'b00;
      // NOTE: the read-data holding registers are architecturally visible
      // and must read zero after reset, so they are reset like control.
      rdata0_q   <= '0;
      rdata1_q   <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      owner_q    <= owner_d;
      bus_addr_q <= bus_addr_d;
      bus_do_q   <= bus_do_d;
      bus_rd_q   <= bus_rd_d;
      bus_wr_q   <= bus_wr_d;
      ack_q      <= ack_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
    end
  end

  assign bus_addr = bus_addr_q;
  assign bus_do   = bus_do_q;
  assign bus_rd   = bus_rd_q;
  assign bus_wr   = bus_wr_q;
  assign m0_ack   = ack_q[0];
  assign m1_ack   = ack_q[1];
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_gpio_bus_arb.sv
// Bench for gpio_bus_arb: a transaction-schedule model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_gpio_bus_arb;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m0_req = 1'b0, m1_req = 1'b0;
  logic       m0_wr = 1'b0, m1_wr = 1'b0;
  logic [7:0] m0_addr = 8'h00, m1_addr = 8'h00;
  logic [7:0] m0_wdata = 8'h00, m1_wdata = 8'h00;
  logic       m0_ack, m1_ack;
  logic [7:0] m0_rdata, m1_rdata;
  logic [7:0] bus_addr, bus_do;
  logic       bus_rd, bus_wr;
  logic [7:0] bus_di = 8'h00;
  logic       busy;

  int n_checks = 0;
  int n_err = 0;

  gpio_bus_arb #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .m0_req   (m0_req),
    .m0_wr    (m0_wr),
    .m0_addr  (m0_addr),
    .m0_wdata (m0_wdata),
    .m0_ack   (m0_ack),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_wr    (m1_wr),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_ack   (m1_ack),
    .m1_rdata (m1_rdata),
    .bus_addr (bus_addr),
    .bus_do   (bus_do),
    .bus_rd   (bus_rd),
    .bus_wr   (bus_wr),
    .bus_di   (bus_di),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Peripheral: read data is a fixed function of the address, registered.
  function automatic logic [7:0] periph(input logic [7:0] a);
    return a ^ 8'h1E;
  endfunction

  always @(posedge clk) bus_di <= periph(bus_addr);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-schedule model ----------------
  int         edge_n = 0;
  int         next_sample = 0;
  int         ack_edge = -1;
  logic       mv = 1'b0;
  logic       last = 1'b1;
  logic       p_owner = 1'b0, p_wr = 1'b0;
  logic [7:0] p_rval = 8'h00;
  logic [7:0] exp_addr = 8'h00, exp_do = 8'h00;
  logic       exp_wr = 1'b0, exp_rd = 1'b0, exp_busy = 1'b0;
  logic [1:0] exp_ack = 2'b00;
  logic [7:0] exp_rd0 = 8'h00, exp_rd1 = 8'h00;

  logic       win_m1;
  logic       win_wr;
  logic [7:0] win_addr, win_wdata;

  function automatic logic pick_m1(input logic r0, input logic r1, input logic lst);
    if (r0 && r1) return !lst;
    return r1;
  endfunction

  assign win_m1    = pick_m1(m0_req, m1_req, last);
  assign win_wr    = win_m1 ? m1_wr : m0_wr;
  assign win_addr  = win_m1 ? m1_addr : m0_addr;
  assign win_wdata = win_m1 ? m1_wdata : m0_wdata;

  // Edge e grants: strobe visible after e, ack after e+1 (write) or e+2
  // (read), next sampling edge e+3 or e+4.
  always @(posedge clk) begin
    edge_n <= edge_n + 1;
    if (reset) begin
      mv          <= 1'b1;
      last        <= 1'b1;
      next_sample <= edge_n + 1;
      ack_edge    <= -1;
      exp_addr    <= 8'h00;
      exp_do      <= 8'h00;
      exp_wr      <= 1'b0;
      exp_rd      <= 1'b0;
      exp_ack     <= 2'b00;
      exp_rd0     <= 8'h00;
      exp_rd1     <= 8'h00;
      exp_busy    <= 1'b0;
    end else begin
      exp_wr   <= 1'b0;
      exp_rd   <= 1'b0;
      exp_ack  <= 2'b00;
      exp_busy <= (edge_n < next_sample - 1);
      if (edge_n == ack_edge) begin
        exp_ack <= p_owner ? 2'b10 : 2'b01;
        if (!p_wr && p_owner)  exp_rd1 <= p_rval;
        if (!p_wr && !p_owner) exp_rd0 <= p_rval;
      end
      if (mv && edge_n >= next_sample && (m0_req || m1_req)) begin
        last        <= win_m1;
        p_owner     <= win_m1;
        p_wr        <= win_wr;
        p_rval      <= periph(win_addr);
        exp_addr    <= win_addr;
        exp_do      <= win_wdata;
        exp_wr      <= win_wr;
        exp_rd      <= !win_wr;
        exp_busy    <= 1'b1;
        ack_edge    <= edge_n + (win_wr ? 1 : 2);
        next_sample <= edge_n + (win_wr ? 3 : 4);
      end
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      check("bus_addr", 32'(bus_addr), 32'(exp_addr));
      check("bus_do",   32'(bus_do),   32'(exp_do));
      check("bus_wr",   32'(bus_wr),   32'(exp_wr));
      check("bus_rd",   32'(bus_rd),   32'(exp_rd));
      check("strobe_excl", 32'(bus_wr & bus_rd), 32'h0);
      check("m0_ack",   32'(m0_ack),   32'(exp_ack[0]));
      check("m1_ack",   32'(m1_ack),   32'(exp_ack[1]));
      check("m0_rdata", 32'(m0_rdata), 32'(exp_rd0));
      check("m1_rdata", 32'(m1_rdata), 32'(exp_rd1));
      check("busy",     32'(busy),     32'(exp_busy));
    end
  end

  // ---------------- directed scenarios ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    repeat (2) tick();
    check("rst_busy",   32'(busy), 32'h0);
    check("rst_bus_wr", 32'(bus_wr), 32'h0);
    check("rst_m0_rd",  32'(m0_rdata), 32'h0);
    check("rst_m1_ack", 32'(m1_ack), 32'h0);
    reset = 1'b0;
    tick();

    // m0 write 0x01 <- 0xA5
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 8'h01; m0_wdata = 8'hA5;
    tick();
    check("wr_strobe", 32'(bus_wr), 32'h1);
    check("wr_addr",   32'(bus_addr), 32'h01);
    check("wr_data",   32'(bus_do), 32'hA5);
    tick();
    check("wr_ack",    32'(m0_ack), 32'h1);
    check("wr_m1_ack", 32'(m1_ack), 32'h0);
    m0_req = 1'b0;
    tick();

    // m1 read 0x42, peripheral returns 0x5C
    m1_req = 1'b1; m1_wr = 1'b0; m1_addr = 8'h42;
    tick();
    check("rd_strobe", 32'(bus_rd), 32'h1);
    check("rd_addr",   32'(bus_addr), 32'h42);
    tick();
    check("rd_wait_no_ack", 32'(m1_ack), 32'h0);
    check("rd_wait_rd",     32'(bus_rd), 32'h0);
    tick();
    check("rd_ack",    32'(m1_ack), 32'h1);
    check("rd_data",   32'(m1_rdata), 32'h5C);
    check("rd_m0_hold", 32'(m0_rdata), 32'h00);
    m1_req = 1'b0;
    tick();

    // m0 read 0x03, address changed after sampling
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 8'h03;
    tick();
    check("late_addr0", 32'(bus_addr), 32'h03);
    m0_addr = 8'h44;
    tick();
    check("late_addr1", 32'(bus_addr), 32'h03);
    tick();
    check("late_addr2", 32'(bus_addr), 32'h03);
    check("late_ack",   32'(m0_ack), 32'h1);
    check("late_data",  32'(m0_rdata), 32'h1D);
    check("late_m1_hold", 32'(m1_rdata), 32'h5C);
    m0_req = 1'b0;
    tick();

    // m0 read aborted by reset in RDWAIT
    m0_req = 1'b1; m0_wr = 1'b0; m0_addr = 8'h10;
    tick();
    tick();
    reset = 1'b1; m0_req = 1'b0;
    tick();
    check("abort_ack",   32'(m0_ack), 32'h0);
    check("abort_rdata", 32'(m0_rdata), 32'h00);
    check("abort_rd",    32'(bus_rd), 32'h0);
    reset = 1'b0;

    // tie from reset: grants alternate m0, m1, m0, m1
    m0_req = 1'b1; m0_wr = 1'b1; m0_addr = 8'h20; m0_wdata = 8'h11;
    m1_req = 1'b1; m1_wr = 1'b1; m1_addr = 8'h30; m1_wdata = 8'h22;
    for (int g = 0; g < 4; g++) begin
      tick();
      check("tie_wr",   32'(bus_wr), 32'h1);
      check("tie_addr", 32'(bus_addr), (g % 2 == 1) ? 32'h30 : 32'h20);
      tick();
      check("tie_ack0", 32'(m0_ack), (g % 2 == 0) ? 32'h1 : 32'h0);
      check("tie_ack1", 32'(m1_ack), (g % 2 == 1) ? 32'h1 : 32'h0);
      tick();
      if (g == 3) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end
    end
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
